set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Streaming set-bit scanner: accepts a WIDTH-bit vector over a valid/ready handshake, then emits the absolute index of every set bit, one index per cycle. Order is LSB-first or MSB-first, selected by parameter. It replaces ad-hoc loops around the combinational first-one finders wherever a consumer must visit all pending requesters in order, such as interrupt pending masks, scoreboard release, and multi-grant arbitration. It sits between a request-vector producer and an index consumer, and both sides are fully back-pressurable.

## Interface
- WIDTH, 32: input vector width; must be >= 1.
- MODE, 0: 0 = ascending index order (LSB first); 1 = descending index order (MSB first).
- IDX_WIDTH, derived: (WIDTH > 1) ? $clog2(WIDTH) : 1.
- ORD_WIDTH, derived: $clog2(WIDTH+1).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous abort; drops the current vector.
- in_i  in  WIDTH  vector to scan.
- in_valid_i  in  1  in_i valid.
- in_ready_o  out  1  block can accept a vector.
- idx_o  out  IDX_WIDTH  absolute bit index of the current set bit.
- ord_o  out  ORD_WIDTH  ordinal of this beat within the vector (0, 1, ...).
- last_o  out  1  final beat of the current vector.
- none_o  out  1  accepted vector was all-zero (single beat).
- out_valid_o  out  1  idx_o/ord_o/last_o/none_o valid.
- out_ready_i  in  1  consumer accepts the beat.

## Operation
- State:
  - FSM is IDLE or SCAN.
  - pending_q holds WIDTH bits.
  - ord_q holds ORD_WIDTH bits.
- IDLE:
  - in_ready_o=1 and out_valid_o=0.
  - On in_valid_i & in_ready_o: pending_q<=in_i, ord_q<=0, go to SCAN.
- SCAN:
  - out_valid_o=1.
  - sel = first set bit of pending_q in MODE order.
    - MODE=0: idx_o = trailing-zero count.
    - MODE=1: idx_o = WIDTH-1-leading-zero count.
  - last_o = (pending_q with bit sel cleared) == 0.
  - none_o = (pending_q == 0). In that case idx_o=0, last_o=1, ord_o=0.
- Beat handshake (out_valid_o & out_ready_i):
  - Clear bit sel in pending_q.
  - ord_q <= ord_q+1.
  - If last_o, return to IDLE, unless a new vector is accepted in the same cycle.
- in_ready_o = !flush_i & (IDLE | (out_valid_o & out_ready_i & last_o)).
  - This is a combinational path from out_ready_i, which permits back-to-back vectors with no bubble.
  - Same-cycle accept loads the new vector, resets ord_q to 0, and stays in SCAN.
- Beat count per vector = max(popcount(in_i), 1).
- Output stability: while out_valid_o=1 and out_ready_i=0, all outputs are held constant. pending_q changes only on a handshake.
- IDLE gating: outputs idx_o, ord_o, last_o and none_o are driven 0 while out_valid_o=0.
- flush_i:
  - Highest priority.
  - Next cycle: IDLE, pending_q=0, ord_q=0.
  - Any in_valid_i in the flush cycle is not accepted, because in_ready_o=0.
  - A beat presented during the flush cycle still completes its handshake if out_ready_i=1; the consumer must tolerate this.
- WIDTH=1: idx_o is always 0. The vector 1 gives one beat with last_o=1.

## Timing
- Reset (rst_ni=0, asynchronous):
  - FSM=IDLE, pending_q=0, ord_q=0.
  - in_ready_o=1, out_valid_o=0, idx_o=0, ord_o=0, last_o=0, none_o=0.
  - Reset mid-scan discards the vector with no further beats.
- Latency: vector accepted at edge N; first beat valid after edge N, so handshake at edge N+1 at the earliest.
- Throughput: one index per cycle with out_ready_i held high.
- Back-to-back: a vector of k set bits occupies k cycles.

## Structure
- Shared package set_bit_iter_pkg contains:
  - typedef enum logic {IDLE, SCAN} state_e;
  - localparams MODE_LSB_FIRST=0 and MODE_MSB_FIRST=1.
- Sub-module: one lzc instance (WIDTH, MODE passed through) on pending_q, giving the count and empty flag.
- Index conversion for MODE=1, bit clear (one-hot decode of idx), and the FSM live in the top module.
- No other sub-modules. Registers are only state, pending_q and ord_q.

## Test plan
- WIDTH=8, MODE=0, in_i=8'b1001_0100, out_ready_i=1 -> three beats on consecutive cycles:
  - idx 2, 4, 7;
  - ord 0, 1, 2;
  - last_o only on idx 7;
  - first beat one cycle after accept.
- Same vector with MODE=1 -> idx 7, 4, 2; last_o on idx 2.
- in_i=8'h00 -> a single beat with none_o=1, last_o=1, idx_o=0, ord_o=0, then back to IDLE.
- Backpressure: in_i=8'hA0 (MODE=0) with out_ready_i=0 for 3 cycles on the first beat -> idx_o=5 and ord_o=0 held stable and in_ready_o=0 throughout; then idx 7 with last_o.
- Back-to-back: 8'h01 then 8'h80 with in_valid_i held -> the second vector is accepted on the last-beat cycle of the first; idx 0 then 7 on consecutive cycles, each with ord_o=0 and last_o=1.
- Abort mid-scan with 8'hFF:
  - flush_i after 2 beats -> next cycle out_valid_o=0 and in_ready_o=1.
  - Repeat with rst_ni low mid-scan -> immediate reset values and no further beats.

Source files
------------

// File: rtl/set_bit_iter_pkg.sv
// rtl/set_bit_iter_pkg.sv - shared types and constants for the set-bit iterator
package set_bit_iter_pkg;

    typedef enum logic {IDLE, SCAN} state_e;

    localparam int MODE_LSB_FIRST = 0;
    localparam int MODE_MSB_FIRST = 1;

endpackage

// File: rtl/set_bit_iterator_lzc.sv
// rtl/set_bit_iterator_lzc.sv - zero counter: trailing zeros (LSB mode) or leading zeros (MSB mode)
module set_bit_iterator_lzc
    import set_bit_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = MODE_LSB_FIRST
) (
    input  logic [WIDTH-1:0]                          in_i,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] cnt_o,
    output logic                                      empty_o
);

    localparam int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Later loop iterations override earlier ones, so the winner is the
    // set bit closest to the scan origin.
    always_comb begin
        cnt_o = '0;
        if (MODE == MODE_LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = IDX_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = IDX_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/set_bit_iterator.sv
// rtl/set_bit_iterator.sv - streams the index of every set bit of an accepted vector
module set_bit_iterator
    import set_bit_iter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MODE      = MODE_LSB_FIRST,
    parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int ORD_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     in_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic [ORD_WIDTH-1:0] ord_o,
    output logic                 last_o,
    output logic                 none_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       pending_q, pending_d;
    logic [ORD_WIDTH-1:0]   ord_q, ord_d;

    logic [IDX_WIDTH-1:0]   cnt;
    logic                   empty;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic [WIDTH-1:0]       sel_oh;
    logic                   last;
    logic                   beat_hs;
    logic                   accept;

    set_bit_iterator_lzc #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_lzc (
        .in_i    (pending_q),
        .cnt_o   (cnt),
        .empty_o (empty)
    );

    always_comb begin
        sel_idx = '0;
        if (!empty) begin
            sel_idx = (MODE == MODE_LSB_FIRST) ? cnt : IDX_WIDTH'(WIDTH - 1) - cnt;
        end
    end

    // An empty vector still produces one beat but must clear nothing.
    assign sel_oh = empty ? '0 : (WIDTH'(1) << sel_idx);
    assign last   = ((pending_q & ~sel_oh) == '0);

    assign out_valid_o = (state_q == SCAN);
    assign beat_hs     = out_valid_o & out_ready_i;
    assign in_ready_o  = !flush_i & ((state_q == IDLE) | (beat_hs & last));
    assign accept      = in_valid_i & in_ready_o;

    assign idx_o  = out_valid_o ? sel_idx : '0;
    assign ord_o  = (out_valid_o && !empty) ? ord_q : '0;
    assign last_o = out_valid_o & last;
    assign none_o = out_valid_o & empty;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ord_d     = ord_q;
        if (flush_i) begin
            state_d   = IDLE;
            pending_d = '0;
            ord_d     = '0;
        end else if (accept) begin
            state_d   = SCAN;
            pending_d = in_i;
            ord_d     = '0;
        end else if (beat_hs) begin
            pending_d = pending_q & ~sel_oh;
            ord_d     = ord_q + ORD_WIDTH'(1);
            if (last) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ord_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ord_q     <= ord_d;
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb/tb_set_bit_iterator.sv - randomized scoreboard bench for set_bit_iterator, both index orders
module tb_set_bit_iterator;

    localparam int W  = 8;
    localparam int IW = 3;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [W-1:0]  vec;
    logic          in_valid;
    logic          out_ready;

    logic          in_ready0, in_ready1;
    logic [IW-1:0] idx0, idx1;
    logic [OW-1:0] ord0, ord1;
    logic          last0, last1, none0, none1, ov0, ov1;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beat index lists for the vector(s) in flight, one per order.
    int exp_lsb[$];
    int exp_msb[$];
    int m_ord;
    bit m_none;

    always #5 clk = ~clk;

    set_bit_iterator #(.WIDTH(W), .MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_i(vec),
        .in_valid_i(in_valid), .in_ready_o(in_ready0), .idx_o(idx0),
        .ord_o(ord0), .last_o(last0), .none_o(none0),
        .out_valid_o(ov0), .out_ready_i(out_ready)
    );

    set_bit_iterator #(.WIDTH(W), .MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_i(vec),
        .in_valid_i(in_valid), .in_ready_o(in_ready1), .idx_o(idx1),
        .ord_o(ord1), .last_o(last1), .none_o(none1),
        .out_valid_o(ov1), .out_ready_i(out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " in_ready0"}, int'(in_ready0), 1);
        check({tag, " in_ready1"}, int'(in_ready1), 1);
        check({tag, " valid0"}, int'(ov0), 0);
        check({tag, " valid1"}, int'(ov1), 0);
        check({tag, " idx0"}, int'(idx0), 0);
        check({tag, " idx1"}, int'(idx1), 0);
        check({tag, " ord0"}, int'(ord0), 0);
        check({tag, " last0"}, int'(last0), 0);
        check({tag, " none0"}, int'(none0), 0);
    endtask

    // One clock: drive at negedge, check combinational outputs against the
    // model, then advance the model to what the following edge produces.
    task automatic cycle(input bit f, input logic [W-1:0] v, input bit iv, input bit ordy);
        bit busy, hs, exp_rdy, acc;
        @(negedge clk);
        flush = f; vec = v; in_valid = iv; out_ready = ordy;
        #1;
        busy    = (exp_lsb.size() > 0);
        hs      = busy && ordy;
        exp_rdy = !f && (!busy || (hs && exp_lsb.size() == 1));
        acc     = iv && exp_rdy;
        check("valid0", int'(ov0), int'(busy));
        check("valid1", int'(ov1), int'(busy));
        check("in_ready0", int'(in_ready0), int'(exp_rdy));
        check("in_ready1", int'(in_ready1), int'(exp_rdy));
        if (busy) begin
            check("idx_lsb", int'(idx0), exp_lsb[0]);
            check("idx_msb", int'(idx1), exp_msb[0]);
            check("ord0", int'(ord0), m_ord);
            check("ord1", int'(ord1), m_ord);
            check("last0", int'(last0), int'(exp_lsb.size() == 1));
            check("last1", int'(last1), int'(exp_msb.size() == 1));
            check("none0", int'(none0), int'(m_none));
            check("none1", int'(none1), int'(m_none));
        end else begin
            check("gated idx0", int'(idx0), 0);
            check("gated ord1", int'(ord1), 0);
            check("gated last0", int'(last0), 0);
            check("gated none1", int'(none1), 0);
        end
        if (hs) begin
            void'(exp_lsb.pop_front());
            void'(exp_msb.pop_front());
            m_ord++;
        end
        if (f) begin
            exp_lsb.delete(); exp_msb.delete(); m_ord = 0;
        end else if (acc) begin
            m_ord  = 0;
            m_none = (v == '0);
            for (int i = 0; i < W; i++) if (v[i]) exp_lsb.push_back(i);
            for (int i = W - 1; i >= 0; i--) if (v[i]) exp_msb.push_back(i);
            if (m_none) begin
                exp_lsb.push_back(0);
                exp_msb.push_back(0);
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; vec = '0;
        #1;
        check_idle_outputs(tag);
        exp_lsb.delete(); exp_msb.delete(); m_ord = 0; m_none = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; vec = '0; in_valid = 1'b0; out_ready = 1'b0;
        m_ord = 0; m_none = 0;
        apply_reset("reset");

        cycle(0, 8'b1001_0100, 1, 1);
        idle(4);

        cycle(0, 8'h00, 1, 1);
        idle(2);

        cycle(0, 8'hA0, 1, 0);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 0);
        idle(3);

        cycle(0, 8'h01, 1, 1);
        cycle(0, 8'h80, 1, 1);
        idle(3);

        cycle(0, 8'hFF, 1, 1);
        cycle(0, '0, 0, 1);
        cycle(0, '0, 0, 1);
        cycle(1, 8'h0F, 1, 1);
        idle(2);

        cycle(0, 8'hFF, 1, 1);
        cycle(0, '0, 0, 1);
        cycle(0, '0, 0, 1);
        apply_reset("reset mid-scan");
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] v;
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = W'(1) << $urandom_range(0, W - 1);
                2:       v = W'($urandom);
                default: v = '1;
            endcase
            cycle(($urandom_range(0, 49) == 0), v, ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
